not_not_round_ctrl: RTL and testbench

//   Round sequencer for the Not Not game. Draws a new prompt from the LFSR/prompt datapath,

---
 rtl/not_not_round_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_not_not_round_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/not_not_round_ctrl.sv
// not_not_round_ctrl: round sequencer for the Not Not game.
// Draws a prompt, times the answer window, judges the switches against
// the datapath's expected mask, and tracks score, lives and game over.
// Optional feature macro: SPEEDUP_EN. It shrinks the answer window after
// each correct answer, down to a floor.
// State encoding on state_out: IDLE=0, LOAD=1, SHOW=2, JUDGE=3, RESULT=4, GAME_OVER=5.
// Handshake: none. start is a level and submit is edge-detected internally.
// Only a fresh rising edge of submit while in SHOW counts as an answer.
module not_not_round_ctrl #(
    parameter int TIMEOUT_CYCLES = 150_000_000,
    parameter int RESULT_CYCLES  = 50_000_000,
    parameter int LIVES          = 3,
    parameter int SCORE_W        = 8,
    parameter int TIMER_W        = 28,
    parameter int TIMEOUT_STEP   = 10_000_000,
    parameter int TIMEOUT_MIN    = 25_000_000
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               start,
    input  logic               submit,
    input  logic [3:0]         player_sw,
    input  logic [3:0]         expected,
    output logic               prompt_next,
    output logic               prompt_visible,
    output logic [TIMER_W-1:0] timer,
    output logic [SCORE_W-1:0] score,
    output logic [2:0]         lives,
    output logic               correct,
    output logic               wrong,
    output logic               game_over,
    output logic [2:0]         state_out
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_SHOW      = 3'd2,
        ST_JUDGE     = 3'd3,
        ST_RESULT    = 3'd4,
        ST_GAME_OVER = 3'd5
    } state_t;

    localparam int                 RES_W      = (RESULT_CYCLES > 1) ? $clog2(RESULT_CYCLES) : 1;
    localparam logic [RES_W-1:0]   RES_LAST   = RES_W'(RESULT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] WIN_MAX_M1 = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]         LIVES_INIT = 3'(LIVES);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [2:0]         lives_q, lives_d;
    logic               correct_q, correct_d;
    logic               wrong_q, wrong_d;
    logic [RES_W-1:0]   res_cnt_q, res_cnt_d;
    logic               submit_q, submit_d;
    logic               prompt_next_q, prompt_next_d;
    logic               prompt_visible_q, prompt_visible_d;
    logic               game_over_q, game_over_d;

    logic               submit_edge;
    logic               match;
    logic [TIMER_W-1:0] load_m1;

    assign submit_edge = submit & ~submit_q;
    assign match       = (player_sw == expected);

`ifdef SPEEDUP_EN
    // Window is stored as (length - 1) so it loads straight into the timer.
    localparam logic [TIMER_W-1:0] WIN_MIN_M1 = TIMER_W'(TIMEOUT_MIN - 1);
    localparam logic [TIMER_W-1:0] WIN_STEP   = TIMER_W'(TIMEOUT_STEP);
    localparam logic [TIMER_W:0]   WIN_FLOOR  = (TIMER_W + 1)'(TIMEOUT_MIN - 1 + TIMEOUT_STEP);

    logic [TIMER_W-1:0] window_m1_q, window_m1_d;
    logic               game_start;
    logic               judge_ok;

    assign game_start = ((state_q == ST_IDLE) || (state_q == ST_GAME_OVER)) && start;
    assign judge_ok   = (state_q == ST_JUDGE) && match;
    assign load_m1    = window_m1_q;

    // Window length: full at game start, shrinks by one step per correct answer down to the floor.
    always_comb begin
        window_m1_d = window_m1_q;
        if (game_start) begin
            window_m1_d = WIN_MAX_M1;
        end else if (judge_ok) begin
            window_m1_d = ({1'b0, window_m1_q} >= WIN_FLOOR) ? (window_m1_q - WIN_STEP) : WIN_MIN_M1;
        end
    end

    // Window register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            window_m1_q <= WIN_MAX_M1;
        end else begin
            window_m1_q <= window_m1_d;
        end
    end
`else
    assign load_m1 = WIN_MAX_M1;
`endif

    // Next-state and datapath updates for the round sequencer.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        score_d   = score_q;
        lives_d   = lives_q;
        correct_d = correct_q;
        wrong_d   = wrong_q;
        res_cnt_d = res_cnt_q;
        submit_d  = submit;
        case (state_q)
            ST_IDLE, ST_GAME_OVER: begin
                if (start) begin
                    score_d = '0;
                    lives_d = LIVES_INIT;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                timer_d = load_m1;
                state_d = ST_SHOW;
            end
            ST_SHOW: begin
                // An answer and expiry in the same cycle still yield one judgement.
                if (submit_edge || (timer_q == '0)) begin
                    state_d = ST_JUDGE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_JUDGE: begin
                res_cnt_d = '0;
                state_d   = ST_RESULT;
                if (match) begin
                    correct_d = 1'b1;
                    if (score_q != SCORE_MAX) begin
                        score_d = score_q + 1'b1;
                    end
                end else begin
                    wrong_d = 1'b1;
                    if (lives_q != 3'd0) begin
                        lives_d = lives_q - 1'b1;
                    end
                end
            end
            ST_RESULT: begin
                if (res_cnt_q == RES_LAST) begin
                    correct_d = 1'b0;
                    wrong_d   = 1'b0;
                    state_d   = (lives_q == 3'd0) ? ST_GAME_OVER : ST_LOAD;
                end else begin
                    res_cnt_d = res_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered status outputs follow the state being entered.
    always_comb begin
        prompt_next_d    = (state_d == ST_LOAD);
        prompt_visible_d = (state_d == ST_SHOW);
        game_over_d      = (state_d == ST_GAME_OVER);
    end

    // State and output registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q          <= ST_IDLE;
            timer_q          <= '0;
            score_q          <= '0;
            lives_q          <= LIVES_INIT;
            correct_q        <= 1'b0;
            wrong_q          <= 1'b0;
            res_cnt_q        <= '0;
            submit_q         <= 1'b0;
            prompt_next_q    <= 1'b0;
            prompt_visible_q <= 1'b0;
            game_over_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            timer_q          <= timer_d;
            score_q          <= score_d;
            lives_q          <= lives_d;
            correct_q        <= correct_d;
            wrong_q          <= wrong_d;
            res_cnt_q        <= res_cnt_d;
            submit_q         <= submit_d;
            prompt_next_q    <= prompt_next_d;
            prompt_visible_q <= prompt_visible_d;
            game_over_q      <= game_over_d;
        end
    end

    assign prompt_next    = prompt_next_q;
    assign prompt_visible = prompt_visible_q;
    assign timer          = timer_q;
    assign score          = score_q;
    assign lives          = lives_q;
    assign correct        = correct_q;
    assign wrong          = wrong_q;
    assign game_over      = game_over_q;
    assign state_out      = state_q;

endmodule

// File: tb/tb_not_not_round_ctrl.sv
// Testbench for not_not_round_ctrl: directed game scenarios with literal
// expectations, then randomized play, with every cycle compared against
// a behavioural model of the game rules.
module tb_not_not_round_ctrl;

    localparam int TO   = 10;
    localparam int RC   = 4;
    localparam int LV   = 3;
    localparam int SW   = 8;
    localparam int TW   = 8;
    localparam int STEP = 3;
    localparam int TMIN = 4;
`ifdef SPEEDUP_EN
    localparam int S3_WIN = 7;
`else
    localparam int S3_WIN = 10;
`endif

    localparam int P_IDLE = 0, P_LOAD = 1, P_SHOW = 2, P_JUDGE = 3, P_RESULT = 4, P_OVER = 5;

    // ---------------- clock / reset ----------------
    logic          clock = 1'b0;
    logic          resetn;
    logic          start, submit;
    logic [3:0]    player_sw, expected;
    logic          prompt_next, prompt_visible, correct, wrong, game_over;
    logic [TW-1:0] timer;
    logic [SW-1:0] score;
    logic [2:0]    lives, state_out;

    always #5 clock = ~clock;

    not_not_round_ctrl #(
        .TIMEOUT_CYCLES(TO), .RESULT_CYCLES(RC), .LIVES(LV), .SCORE_W(SW),
        .TIMER_W(TW), .TIMEOUT_STEP(STEP), .TIMEOUT_MIN(TMIN)
    ) dut (
        .clock(clock), .resetn(resetn), .start(start), .submit(submit),
        .player_sw(player_sw), .expected(expected),
        .prompt_next(prompt_next), .prompt_visible(prompt_visible),
        .timer(timer), .score(score), .lives(lives),
        .correct(correct), .wrong(wrong), .game_over(game_over),
        .state_out(state_out)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int m_phase, m_timer, m_score, m_lives, m_res_left, m_window;
    bit m_correct, m_wrong, m_sub_prev;

    task automatic model_reset();
        m_phase = P_IDLE; m_timer = 0; m_score = 0; m_lives = LV;
        m_correct = 0; m_wrong = 0; m_res_left = 0; m_sub_prev = 0; m_window = TO;
    endtask

    // One clock of game rules, using the inputs present at the edge.
    task automatic model_step();
        bit answered;
        answered   = submit && !m_sub_prev;
        m_sub_prev = submit;
        if (m_phase == P_IDLE || m_phase == P_OVER) begin
            if (start) begin
                m_score = 0; m_lives = LV; m_window = TO; m_phase = P_LOAD;
            end
        end else if (m_phase == P_LOAD) begin
            m_timer = m_window - 1; m_phase = P_SHOW;
        end else if (m_phase == P_SHOW) begin
            if (answered || m_timer == 0) m_phase = P_JUDGE;
            else m_timer = m_timer - 1;
        end else if (m_phase == P_JUDGE) begin
            if (player_sw == expected) begin
                m_correct = 1;
                m_score   = (m_score + 1 > (1 << SW) - 1) ? (1 << SW) - 1 : m_score + 1;
`ifdef SPEEDUP_EN
                m_window  = (m_window - STEP < TMIN) ? TMIN : m_window - STEP;
`endif
            end else begin
                m_wrong = 1;
                m_lives = m_lives - 1;
            end
            m_res_left = RC;
            m_phase    = P_RESULT;
        end else begin
            m_res_left = m_res_left - 1;
            if (m_res_left == 0) begin
                m_correct = 0; m_wrong = 0;
                m_phase   = (m_lives == 0) ? P_OVER : P_LOAD;
            end
        end
    endtask

    // The single compare process against the model.
    task automatic compare_all();
        chk("state",          int'(state_out),      m_phase);
        chk("prompt_next",    int'(prompt_next),    int'(m_phase == P_LOAD));
        chk("prompt_visible", int'(prompt_visible), int'(m_phase == P_SHOW));
        chk("game_over",      int'(game_over),      int'(m_phase == P_OVER));
        chk("timer",          int'(timer),          m_timer);
        chk("score",          int'(score),          m_score);
        chk("lives",          int'(lives),          m_lives);
        chk("correct",        int'(correct),        int'(m_correct));
        chk("wrong",          int'(wrong),          int'(m_wrong));
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge: advance one clock, then compare at the next falling edge.
    task automatic step();
        @(posedge clock);
        if (resetn) model_step();
        else model_reset();
        @(negedge clock);
        compare_all();
    endtask

    task automatic wait_state(input int s, input int budget, output int n);
        n = 0;
        while (int'(state_out) != s && n < budget) begin
            step();
            n++;
        end
        chk("wait_state", int'(state_out), s);
    endtask

    // Count cycles spent in SHOW, starting from the first SHOW cycle.
    task automatic count_show(output int n);
        n = 0;
        while (int'(state_out) == P_SHOW && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic async_reset_pulse();
        resetn = 1'b0;
        #1;
        model_reset();
        compare_all();
        step();
        resetn = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        resetn = 1'b0; start = 1'b0; submit = 1'b0; player_sw = 4'd0; expected = 4'd0;
        model_reset();
        repeat (2) @(negedge clock);
        compare_all();
        resetn = 1'b1;
        chk("reset_state", int'(state_out), P_IDLE);
        chk("reset_lives", int'(lives), 3);
        chk("reset_score", int'(score), 0);
        chk("reset_prompt_next", int'(prompt_next), 0);
        step();
        chk("idle_hold", int'(state_out), P_IDLE);

        // 1. start -> LOAD with one prompt_next pulse, then SHOW with timer 9
        start = 1'b1;
        step();
        chk("s1_load", int'(state_out), P_LOAD);
        chk("s1_prompt_next", int'(prompt_next), 1);
        start = 1'b0;
        step();
        chk("s1_show", int'(state_out), P_SHOW);
        chk("s1_timer", int'(timer), 9);
        chk("s1_prompt_next_low", int'(prompt_next), 0);

        // 2. matching answer via submit edge
        expected = 4'b0110; player_sw = 4'b0110; submit = 1'b1;
        step();
        chk("s2_judge", int'(state_out), P_JUDGE);
        submit = 1'b0;
        step();
        chk("s2_correct", int'(correct), 1);
        chk("s2_score", int'(score), 1);
        n = 0;
        while (correct && n < 20) begin
            n++;
            step();
        end
        chk("s2_correct_cycles", n, 4);
        chk("s2_back_to_load", int'(state_out), P_LOAD);

        // 3. timeout with expected=0 and switches off is correct
        expected = 4'b0000; player_sw = 4'b0000;
        step();
        count_show(n);
        chk("s3_show_dwell", n, S3_WIN);
        chk("s3_judge", int'(state_out), P_JUDGE);
        step();
        chk("s3_correct", int'(correct), 1);
        chk("s3_lives", int'(lives), 3);
        wait_state(P_LOAD, 20, n);
        expected = 4'b1000;
        wait_state(P_JUDGE, 40, n);
        step();
        chk("s3_wrong", int'(wrong), 1);
        chk("s3_lives_after", int'(lives), 2);

        // 4. keep losing until game over; score holds, start restarts
        wait_state(P_OVER, 200, n);
        chk("s4_lives", int'(lives), 0);
        chk("s4_game_over", int'(game_over), 1);
        chk("s4_score_held", int'(score), 2);
        chk("s4_model_score", m_score, 2);
        repeat (3) step();
        chk("s4_over_hold", int'(state_out), P_OVER);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("s4_restart_load", int'(state_out), P_LOAD);
        chk("s4_restart_score", int'(score), 0);
        chk("s4_restart_lives", int'(lives), 3);

        // 5. submit held through LOAD is not an answer; then async reset mid-SHOW
        submit = 1'b1; player_sw = 4'd5; expected = 4'd5;
        step();
        count_show(n);
        chk("s5_held_submit_dwell", n, 10);
        submit = 1'b0;
        step();
        chk("s5_correct", int'(correct), 1);
        wait_state(P_SHOW, 30, n);
        repeat (3) step();
        chk("s5_score_before_reset", int'(score), 1);
        async_reset_pulse();
        chk("s5_reset_state", int'(state_out), P_IDLE);
        chk("s5_reset_lives", int'(lives), 3);
        chk("s5_reset_score", int'(score), 0);
        chk("s5_reset_visible", int'(prompt_visible), 0);

        // Randomized play against the model
        for (int i = 0; i < 4000; i++) begin
            start     = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) submit = ~submit;
            player_sw = 4'($urandom_range(0, 15));
            expected  = ($urandom_range(0, 1) == 1) ? player_sw : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 599) == 0) async_reset_pulse();
            else step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
